cla_adder_arbiter: RTL
======================

// Module: cla_adder_arbiter
// PURPOSE
//  Shares one 32-bit carry_lookahead_adder between NUM_REQ requesters (ALU, AGU, branch unit, ...).
//  Arbitration is round-robin. Each requester issues add/sub ops over a valid/ready handshake.
//  Results return through a single registered response port, tagged with the requester id.
//  Sits between the issue logic and the shared adder; absorbs response backpressure with a 1-entry output register.
// PARAMETERS
//  NUM_REQ  4                  number of requesters, legal range 2..8
//  ID_W     $clog2(NUM_REQ)    width of the requester id (derived, do not override)
// PORTS
//  clk            in   1           single clock, rising edge
//  rst            in   1           asynchronous, active-high reset
//  req_valid      in   NUM_REQ     per-requester op valid
//  req_ready      out  NUM_REQ     per-requester accept; transfer = valid & ready
//  req_a          in   NUM_REQ*32  operand A, requester i at [i*32 +: 32]
//  req_b          in   NUM_REQ*32  operand B, same packing
//  req_sub        in   NUM_REQ     1 = A - B, 0 = A + B
//  resp_valid     out  1           result valid
//  resp_ready     in   1           consumer accepts result
//  resp_id        out  ID_W        index of the requester that issued the op
//  resp_sum       out  32          A+B or A-B, modulo 2^32
//  resp_carry     out  1           adder carry_out (sub: 1 = no borrow)
//  resp_overflow  out  1           signed overflow
// BEHAVIOUR
//  - Reset (async, immediate): resp_valid=0, resp_id=0, resp_sum=0, resp_carry=0, resp_overflow=0, rr_ptr=0.
//    A held result is discarded. req_ready is all-zero while rst is high.
//  - Output register FSM: EMPTY (resp_valid=0) / FULL (resp_valid=1).
//      can_accept = EMPTY | (FULL & resp_ready).
//      EMPTY->FULL on grant. FULL->EMPTY on resp_ready with no grant. FULL->FULL on resp_ready with a grant.
//      FULL stays FULL (outputs stable) when resp_ready=0.
//  - Grant: winner = first i with req_valid[i], searching rr_ptr, rr_ptr+1, ... wrapping modulo NUM_REQ.
//    req_ready = onehot(winner) & {NUM_REQ{can_accept}}, at most one bit set.
//    req_ready depends combinationally on req_valid. Requesters must not gate valid on ready, and
//    must hold operands stable until the transfer.
//  - On a transfer: adder a = req_a[w], b = req_sub[w] ? ~req_b[w] : req_b[w], carry_in = req_sub[w].
//    Next edge registers sum, carry_out, id = w, and
//    overflow = (a[31] == b'[31]) & (sum[31] != a[31]), where b' is the post-inversion operand.
//    rr_ptr <= (w == NUM_REQ-1) ? 0 : w+1. rr_ptr is unchanged when there is no transfer.
//  - Latency 1 cycle (transfer edge -> resp_valid). Throughput 1 op/cycle while resp_ready=1.
//  - No combinational path from req_* or resp_ready to any resp_* output.
//  - No valid requests: no grant, rr_ptr held, FSM follows resp_ready only.
//  - Starvation bound: a requester holding valid is granted within NUM_REQ accepting cycles.
// STRUCTURE
//  - Package cla_arb_pkg: ADD_W = 32; typedef struct packed {id, sum, carry, overflow} arb_resp_t
//    (id sized for NUM_REQ max 8, i.e. 3 bits).
//  - Sub-module rr_pick: inputs valid vector + pointer, output one-hot winner + index. Purely combinational.
//  - One carry_lookahead_adder instance, unmodified. The output register and FSM live in the top.
// TESTING
//  1. req0 add a=32'h0000_0001 b=32'hFFFF_FFFF, resp_ready=1
//       -> next cycle resp_valid=1, id=0, sum=0, carry=1, ovf=0.
//  2. req2 sub a=5 b=7
//       -> sum=32'hFFFF_FFFE, carry=0, ovf=0, id=2.
//  3. req1 add a=32'h7FFF_FFFF b=1 -> sum=32'h8000_0000, carry=0, ovf=1.
//     req1 sub a=32'h8000_0000 b=1 -> sum=32'h7FFF_FFFF, ovf=1.
//  4. All 4 req_valid held high, resp_ready=1, from reset
//       -> resp_id sequence 0,1,2,3,0,1 on consecutive cycles, one req_ready bit per cycle.
//  5. Grant to req3, then resp_ready=0 for 3 cycles with req0/req1 valid
//       -> resp_* stable, req_ready=0; on release the same cycle grants req0 (ptr wrapped), resp_id=0 next.
//  6. rst asserted mid-cycle while resp_valid=1 -> resp_valid=0 before the next edge.
//     After release, req1+req2 valid -> req1 granted first (rr_ptr=0).
//  Checks: ready one-hot, no transfer while rst is high, scoreboard sum/carry/ovf vs 33-bit reference model.

Source files
------------

// File: rtl/cla_arb_pkg.sv
// Shared types and helpers for the round-robin adder arbiter.
// The response record is sized for the largest supported requester count (8).
package cla_arb_pkg;

  localparam int ADD_W    = 32;
  localparam int MAX_ID_W = 3;

  typedef struct packed {
    logic [MAX_ID_W-1:0] id;
    logic [ADD_W-1:0]    sum;
    logic                carry;
    logic                overflow;
  } arb_resp_t;

  // Signed overflow from the sign bits of the adder inputs (b already inverted for sub) and the sum.
  function automatic logic add_overflow(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) & (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/carry_lookahead_adder.sv
// Carry-lookahead adder built from 4-bit lookahead groups chained on group carry.
// WIDTH must be a multiple of 4.
module carry_lookahead_adder #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int NG = WIDTH / 4;

  logic [WIDTH-1:0] gen_s;
  logic [WIDTH-1:0] prop_s;
  logic [WIDTH:0]   carry_s;

  // Generate/propagate and per-group lookahead carries.
  always_comb begin
    gen_s      = a & b;
    prop_s     = a ^ b;
    carry_s    = '0;
    carry_s[0] = cin;
    for (int k = 0; k < NG; k++) begin
      carry_s[4*k+1] = gen_s[4*k]
                     | (prop_s[4*k] & carry_s[4*k]);
      carry_s[4*k+2] = gen_s[4*k+1]
                     | (prop_s[4*k+1] & gen_s[4*k])
                     | (prop_s[4*k+1] & prop_s[4*k] & carry_s[4*k]);
      carry_s[4*k+3] = gen_s[4*k+2]
                     | (prop_s[4*k+2] & gen_s[4*k+1])
                     | (prop_s[4*k+2] & prop_s[4*k+1] & gen_s[4*k])
                     | (prop_s[4*k+2] & prop_s[4*k+1] & prop_s[4*k] & carry_s[4*k]);
      carry_s[4*k+4] = gen_s[4*k+3]
                     | (prop_s[4*k+3] & gen_s[4*k+2])
                     | (prop_s[4*k+3] & prop_s[4*k+2] & gen_s[4*k+1])
                     | (prop_s[4*k+3] & prop_s[4*k+2] & prop_s[4*k+1] & gen_s[4*k])
                     | (prop_s[4*k+3] & prop_s[4*k+2] & prop_s[4*k+1] & prop_s[4*k] & carry_s[4*k]);
    end
  end

  assign sum  = prop_s ^ carry_s[WIDTH-1:0];
  assign cout = carry_s[WIDTH];

endmodule

// File: rtl/cla_adder_arbiter_rr_pick.sv
// Round-robin picker: first valid requester at or after ptr_i, wrapping modulo NUM_REQ.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] valid_i,
  input  logic [ID_W-1:0]    ptr_i,
  output logic [NUM_REQ-1:0] onehot_o,
  output logic [ID_W-1:0]    idx_o,
  output logic               any_o
);

  logic [ID_W:0]   pos_s;
  logic [ID_W-1:0] cand_s;
  logic            found_s;

  // Scan from the pointer; the first hit wins and later candidates are ignored.
  always_comb begin
    pos_s    = '0;
    cand_s   = '0;
    found_s  = 1'b0;
    idx_o    = '0;
    onehot_o = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      pos_s = {1'b0, ptr_i} + (ID_W+1)'(k);
      if (pos_s >= (ID_W+1)'(NUM_REQ)) begin
        pos_s = pos_s - (ID_W+1)'(NUM_REQ);
      end else begin
        pos_s = pos_s;
      end
      cand_s = pos_s[ID_W-1:0];
      if (!found_s && valid_i[cand_s]) begin
        found_s          = 1'b1;
        idx_o            = cand_s;
        onehot_o[cand_s] = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

  assign any_o = found_s;

endmodule

// File: rtl/cla_adder_arbiter.sv
// Round-robin arbiter sharing one 32-bit carry-lookahead adder across NUM_REQ requesters.
// Results sit in a single registered response slot that absorbs consumer backpressure.
module cla_adder_arbiter
  import cla_arb_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*ADD_W-1:0] req_a,
  input  logic [NUM_REQ*ADD_W-1:0] req_b,
  input  logic [NUM_REQ-1:0]       req_sub,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [ID_W-1:0]          resp_id,
  output logic [ADD_W-1:0]         resp_sum,
  output logic                     resp_carry,
  output logic                     resp_overflow
);

  localparam logic ST_EMPTY = 1'b0;
  localparam logic ST_FULL  = 1'b1;

  logic            state_q, state_d;
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
  arb_resp_t       resp_q, resp_d;

  logic [NUM_REQ-1:0] win_onehot_s;
  logic [ID_W-1:0]    win_idx_s;
  logic               win_any_s;
  logic               can_accept_s;
  logic               grant_s;
  logic [ADD_W-1:0]   op_a_s, op_b_s, op_b_eff_s, add_sum_s;
  logic               op_sub_s, add_cout_s;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_pick (
    .valid_i  (req_valid),
    .ptr_i    (rr_ptr_q),
    .onehot_o (win_onehot_s),
    .idx_o    (win_idx_s),
    .any_o    (win_any_s)
  );

  assign can_accept_s = (state_q == ST_EMPTY) | resp_ready;
  assign grant_s      = win_any_s & can_accept_s & ~rst;

  // Handshake: at most one ready bit, and none while reset is asserted.
  always_comb begin
    if (rst) begin
      req_ready = '0;
    end else begin
      req_ready = win_onehot_s & {NUM_REQ{can_accept_s}};
    end
  end

  // Operand mux for the winning requester; sub feeds ~B with carry-in 1.
  always_comb begin
    op_a_s   = '0;
    op_b_s   = '0;
    op_sub_s = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (win_idx_s == ID_W'(k)) begin
        op_a_s   = req_a[k*ADD_W +: ADD_W];
        op_b_s   = req_b[k*ADD_W +: ADD_W];
        op_sub_s = req_sub[k];
      end else begin
        op_sub_s = op_sub_s;
      end
    end
    op_b_eff_s = op_sub_s ? ~op_b_s : op_b_s;
  end

  carry_lookahead_adder #(
    .WIDTH (ADD_W)
  ) u_adder (
    .a    (op_a_s),
    .b    (op_b_eff_s),
    .cin  (op_sub_s),
    .sum  (add_sum_s),
    .cout (add_cout_s)
  );

  // Output-slot FSM, response capture and pointer advance.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    resp_d   = resp_q;
    if (grant_s) begin
      resp_d.id       = MAX_ID_W'(win_idx_s);
      resp_d.sum      = add_sum_s;
      resp_d.carry    = add_cout_s;
      resp_d.overflow = add_overflow(op_a_s[ADD_W-1], op_b_eff_s[ADD_W-1], add_sum_s[ADD_W-1]);
      if (win_idx_s == ID_W'(NUM_REQ-1)) begin
        rr_ptr_d = '0;
      end else begin
        rr_ptr_d = win_idx_s + ID_W'(1);
      end
    end else begin
      rr_ptr_d = rr_ptr_q;
    end
    case (state_q)
      ST_EMPTY: begin
        if (grant_s) begin
          state_d = ST_FULL;
        end else begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (resp_ready && !grant_s) begin
          state_d = ST_EMPTY;
        end else begin
          state_d = ST_FULL;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
  end

  // State registers with asynchronous reset; a held result is dropped on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_EMPTY;
      rr_ptr_q <= '0;
      resp_q   <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      resp_q   <= resp_d;
    end
  end

  assign resp_valid    = state_q;
  assign resp_id       = resp_q.id[ID_W-1:0];
  assign resp_sum      = resp_q.sum;
  assign resp_carry    = resp_q.carry;
  assign resp_overflow = resp_q.overflow;

endmodule
